// File: rtl/mac_pkg.sv
// mac_pkg: shared state type and sizing constants for the sequential MAC
package mac_pkg;
  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} mac_state_t;
  localparam int OP_W = 16;
  localparam int ACC_W = 32;
  localparam int MUL_CYCLES = 16;
endpackage

// File: rtl/rca.sv
// rca: 32-bit ripple-carry adder shared by the multiply and accumulate steps
module rca (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout
);
  logic [32:0] c;
  assign c[0] = Cin;
  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign Sum[i] = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign Cout = c[32];
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: shift-and-add 16x16 multiply then accumulate, all on one adder
module mac_seq_ctrl #(
  parameter int OP_W   = 16,
  parameter bit SAT_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] out_acc,
  output logic              out_ovf,
  output logic              busy
);
  import mac_pkg::*;
  mac_state_t state, nxt;
  logic [ACC_W-1:0] acc, prod, mcand, add_a, add_b, sum;
  logic [OP_W-1:0] mplr;
  logic [3:0] cnt;
  logic clr_q, cout;
  rca u_rca (.A(add_a), .B(add_b), .Cin(1'b0), .Sum(sum), .Cout(cout));
  // adder operands: partial product step in MUL, accumulate step in ACC
  always_comb begin
    add_a = (state == ACC) ? (clr_q ? '0 : acc) : prod;
    add_b = (state == ACC) ? prod : mcand;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: accept in IDLE, 16 multiply steps, one accumulate, hold until consumed
  always_comb begin
    nxt = state;
    nxt = (state == IDLE) ? (in_valid ? MUL : IDLE)
        : (state == MUL)  ? ((cnt == 4'(MUL_CYCLES - 1)) ? ACC : MUL)
        : (state == ACC)  ? DONE
        : (out_ready ? IDLE : DONE);
  end
  // datapath registers; nothing changes outside accept, MUL and ACC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      prod <= '0;
      mcand <= '0;
      mplr <= '0;
      cnt <= '0;
      clr_q <= 1'b0;
      out_ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      mcand <= {{(ACC_W - OP_W){1'b0}}, in_a};
      mplr <= in_b;
      prod <= '0;
      cnt <= '0;
      clr_q <= in_clr;
      out_ovf <= 1'b0;
    end else if (state == MUL) begin
      if (mplr[0]) prod <= sum;
      mcand <= mcand << 1;
      mplr <= mplr >> 1;
      cnt <= cnt + 4'd1;
    end else if (state == ACC) begin
      acc <= (SAT_EN && cout) ? '1 : sum;
      out_ovf <= cout;
    end
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy = (state != IDLE);
  assign out_acc = acc;
  mul_no_carry: assert property (@(posedge clk) disable iff (!rst_n) state == MUL |-> !cout);
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: table vectors, corner sequences and random ops against a product-sum model
module tb_mac_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_clr = 1'b0, out_ready = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1, busy0, busy1;
  logic [31:0] acc0, acc1;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_acc [2];
  logic m_ovf [2];

  always #5 clk = ~clk;

  mac_seq_ctrl #(.OP_W(16), .SAT_EN(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .in_clr(in_clr), .out_valid(out_valid0), .out_ready(out_ready), .out_acc(acc0), .out_ovf(ovf0), .busy(busy0));
  mac_seq_ctrl #(.OP_W(16), .SAT_EN(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .in_clr(in_clr), .out_valid(out_valid1), .out_ready(out_ready), .out_acc(acc1), .out_ovf(ovf1), .busy(busy1));

  typedef struct {
    logic [15:0] a, b;
    logic clr;
    logic [31:0] acc_w;
    logic ovf_w;
    logic [31:0] acc_s;
    logic ovf_s;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic [15:0] a, input logic [15:0] b, input logic clr);
    for (int s = 0; s < 2; s++) begin
      longint t;
      t = (clr ? 64'd0 : longint'(m_acc[s])) + longint'(a) * longint'(b);
      m_ovf[s] = t > 64'hFFFF_FFFF;
      m_acc[s] = (s == 1 && m_ovf[s]) ? 32'hFFFF_FFFF : t[31:0];
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_in_ready"}, {in_ready0, in_ready1}, 2'b11);
    chk({name, "_busy"}, {busy0, busy1}, 2'b00);
    chk({name, "_out_valid"}, {out_valid0, out_valid1}, 2'b00);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic clr);
    int w;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_clr = clr;
    w = 0;
    while (!(in_ready0 && in_ready1) && w < 40) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    if (w >= 40) chk("accept_timeout", 32'(w), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if ((out_valid0 && out_valid1) || n >= 40) break;
      if (n == 8) begin
        chk({name, "_busy_mid"}, {busy0, busy1, in_ready0, in_ready1}, 4'b1100);
      end
      @(posedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'd17);
  endtask

  task automatic finish_result(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_idle({name, "_after"});
  endtask

  task automatic check_model(input string name);
    chk({name, "_acc_wrap"}, acc0, m_acc[0]);
    chk({name, "_ovf_wrap"}, 32'(ovf0), 32'(m_ovf[0]));
    chk({name, "_acc_sat"}, acc1, m_acc[1]);
    chk({name, "_ovf_sat"}, 32'(ovf1), 32'(m_ovf[1]));
  endtask

  initial begin
    vecs[0] = '{16'd3, 16'd5, 1'b1, 32'h0000_000F, 1'b0, 32'h0000_000F, 1'b0};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0010, 1'b0, 32'hFFFE_0010, 1'b0};
    vecs[2] = '{16'hFFFF, 16'd2, 1'b0, 32'h0000_000E, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{16'd1, 16'd1, 1'b0, 32'h0000_000F, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{16'd0, 16'd0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    m_acc[0] = '0;
    m_acc[1] = '0;
    m_ovf[0] = 1'b0;
    m_ovf[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");
    chk("reset_acc", acc0 | acc1, 32'd0);
    chk("reset_ovf", {ovf0, ovf1}, 2'b00);

    for (int i = 0; i < 5; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].clr);
      model_op(vecs[i].a, vecs[i].b, vecs[i].clr);
      wait_result($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_acc_wrap", i), acc0, vecs[i].acc_w);
      chk($sformatf("vec%0d_ovf_wrap", i), 32'(ovf0), 32'(vecs[i].ovf_w));
      chk($sformatf("vec%0d_acc_sat", i), acc1, vecs[i].acc_s);
      chk($sformatf("vec%0d_ovf_sat", i), 32'(ovf1), 32'(vecs[i].ovf_s));
      finish_result($sformatf("vec%0d", i));
    end

    start_op(16'd2, 16'd3, 1'b1);
    model_op(16'd2, 16'd3, 1'b1);
    wait_result("bp");
    in_valid = 1'b1;
    in_a = 16'd100;
    in_b = 16'd10;
    in_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {out_valid0, out_valid1, in_ready0, in_ready1}, 4'b1100);
      chk("bp_hold_acc", acc0, 32'd6);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_idle("bp_idle");
    @(posedge clk);
    #1 in_valid = 1'b0;
    model_op(16'd100, 16'd10, 1'b0);
    wait_result("bp_next");
    check_model("bp_next");
    chk("bp_next_acc", acc0, 32'd1006);
    finish_result("bp_next");

    start_op(16'd1234, 16'd5678, 1'b0);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_acc", acc0 | acc1, 32'd0);
    chk("midrst_flags", {busy0, busy1, out_valid0, out_valid1, ovf0, ovf1}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_acc[0] = '0;
    m_acc[1] = '0;
    m_ovf[0] = 1'b0;
    m_ovf[1] = 1'b0;
    @(negedge clk);
    check_idle("midrst_idle");
    start_op(16'd7, 16'd9, 1'b1);
    model_op(16'd7, 16'd9, 1'b1);
    wait_result("after_rst");
    chk("after_rst_acc", acc0, 32'd63);
    check_model("after_rst");
    finish_result("after_rst");

    start_op(16'd0, 16'hFFFF, 1'b0);
    model_op(16'd0, 16'hFFFF, 1'b0);
    wait_result("zero");
    chk("zero_acc", acc0, 32'd63);
    check_model("zero");
    finish_result("zero");

    for (int r = 0; r < 20; r++) begin
      logic [15:0] a, b;
      logic clr;
      a = (r % 3 == 0) ? 16'(16'hF000 | $urandom) : 16'($urandom);
      b = 16'($urandom);
      clr = ($urandom_range(0, 3) == 0);
      start_op(a, b, clr);
      model_op(a, b, clr);
      wait_result($sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_hold", {out_valid0, out_valid1}, 2'b11);
      end
      check_model($sformatf("rnd%0d", r));
      finish_result($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
